// File: rtl/core_output_ctrl.sv
// core_output_ctrl: de-skews per-row PE array results through row FIFOs
// and serialises each complete vector onto one valid/ready stream.
module core_output_ctrl #(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ROWS*OUTWIDTH-1:0] res_in,
  input  logic [ROWS-1:0]          res_valid,
  output logic [OUTWIDTH-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     array_stall,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;

  logic [OUTWIDTH-1:0] mem [ROWS][DEPTH];
  logic [PW-1:0]       wptr [ROWS];
  logic [PW-1:0]       rptr [ROWS];
  logic [CW-1:0]       cnt  [ROWS];

  logic [ROWS-1:0] full;
  logic [ROWS-1:0] nempty;
  logic [ROWS-1:0] wr;
  logic [ROWS-1:0] drop;
  logic            pop;
  logic            xfer;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-row status; a full FIFO still takes a write when it pops that cycle.
  always_comb begin
    full   = '0;
    nempty = '0;
    wr     = '0;
    drop   = '0;
    for (int r = 0; r < ROWS; r++) begin
      full[r]   = (cnt[r] == CW'(DEPTH));
      nempty[r] = (cnt[r] != '0);
      wr[r]     = res_valid[r] & (~full[r] | pop);
      drop[r]   = res_valid[r] & full[r] & ~pop;
    end
  end

  // FIFO storage, no reset needed on the data array.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (wr[r]) begin
        mem[r][wptr[r]] <= res_in[r*OUTWIDTH +: OUTWIDTH];
      end
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++) begin
        wptr[r] <= '0;
        rptr[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr[r]) begin
          wptr[r] <= inc(wptr[r]);
        end
        if (pop) begin
          rptr[r] <= inc(rptr[r]);
        end
        if (wr[r] && !pop) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (!wr[r] && pop) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for any dropped write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end
  end

  // FSM state and row index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state and stream outputs; all rows pop together on the last word.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    xfer      = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (&nempty) begin
          state_nx = DRAIN;
          idx_nx   = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[idx][rptr[idx]];
        out_last  = (idx == IW'(ROWS - 1));
        xfer      = out_ready;
        if (xfer) begin
          if (out_last) begin
            pop      = 1'b1;
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign array_stall = |full;

endmodule

// File: tb/tb_core_output_ctrl.sv
// tb_core_output_ctrl: queue-based reference model plus directed and
// randomized traffic for core_output_ctrl.
module tb_core_output_ctrl;

  localparam int ROWS  = 8;
  localparam int OW    = 32;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [ROWS*OW-1:0]   res_in = '0;
  logic [ROWS-1:0]      res_valid = '0;
  logic                 out_ready = 1'b0;
  logic [OW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 array_stall;
  logic                 overflow;

  core_output_ctrl #(
    .ROWS    (ROWS),
    .OUTWIDTH(OW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .array_stall(array_stall),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: one queue per row, a vector in flight and a word
  // position within it.
  logic [31:0] q [ROWS][$];
  bit          active = 0;
  int          sent = 0;
  bit          ovf = 0;
  logic [32:0] got [$];

  task automatic model_step();
    bit pop;
    bit allne;
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++) q[r].delete();
      active = 0;
      sent   = 0;
      ovf    = 0;
      return;
    end
    pop   = active && out_ready && (sent == ROWS - 1);
    allne = 1;
    for (int r = 0; r < ROWS; r++)
      if (q[r].size() == 0) allne = 0;
    for (int r = 0; r < ROWS; r++) begin
      bit full;
      full = (q[r].size() == DEPTH);
      if (pop) void'(q[r].pop_front());
      if (res_valid[r]) begin
        if (!full || pop) q[r].push_back(res_in[r*OW +: OW]);
        else ovf = 1;
      end
    end
    if (active && out_ready) begin
      if (sent == ROWS - 1) active = 0;
      else sent++;
    end else if (!active && allne) begin
      active = 1;
      sent   = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle at the falling edge.
  initial forever begin
    logic [31:0] ed;
    bit          es;
    @(negedge clk);
    if (!rstn) begin
      chk("rst_valid", {31'b0, out_valid}, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", {31'b0, out_last}, 0);
      chk("rst_stall", {31'b0, array_stall}, 0);
      chk("rst_ovf", {31'b0, overflow}, 0);
    end else begin
      ed = active ? q[sent][0] : 32'h0;
      es = 0;
      for (int r = 0; r < ROWS; r++)
        if (q[r].size() == DEPTH) es = 1;
      chk("valid", {31'b0, out_valid}, {31'b0, active});
      chk("data", out_data, ed);
      chk("last", {31'b0, out_last},
          {31'b0, active && (sent == ROWS - 1)});
      chk("stall", {31'b0, array_stall}, {31'b0, es});
      chk("ovf", {31'b0, overflow}, {31'b0, ovf});
      if (out_valid && out_ready) got.push_back({out_last, out_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input int base);
    for (int k = 0; k < ROWS; k++) begin
      res_valid = '0;
      res_valid[k] = 1'b1;
      res_in = '0;
      res_in[k*OW +: OW] = base + k;
      tick();
    end
    res_valid = '0;
    res_in    = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic check_got(input string n, input int nvec,
                           input int b0, input int stride);
    chk({n, "_cnt"}, got.size(), nvec * ROWS);
    for (int v = 0; v < nvec; v++)
      for (int i = 0; i < ROWS; i++)
        if (v * ROWS + i < got.size())
          chk({n, "_word"}, got[v*ROWS+i],
              {(i == ROWS - 1), 32'(b0 + stride * v + i)});
  endtask

  initial begin
    int pat [6];
    bit found;
    pat = '{0, 1, 0, 0, 1, 1};

    // 1: reset with random inputs, then idle
    rstn = 1'b0;
    repeat (5) begin
      tick();
      res_valid = ROWS'($urandom);
      res_in    = {ROWS{$urandom}};
      out_ready = 1'($urandom);
      chk("t1_valid", {31'b0, out_valid}, 0);
      chk("t1_data", out_data, 0);
    end
    res_valid = '0;
    res_in    = '0;
    out_ready = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (10) begin
      tick();
      chk("t1_idle", {31'b0, out_valid}, 0);
    end

    // 2: single skewed vector, ready high
    got.delete();
    push_vec(100);
    chk("t2_lat_lo", {31'b0, out_valid}, 0);
    tick();
    chk("t2_lat_hi", {31'b0, out_valid}, 1);
    chk("t2_first", out_data, 100);
    repeat (20) tick();
    check_got("t2", 1, 100, 0);

    // 3: backpressure pattern
    got.delete();
    out_ready = 1'b0;
    push_vec(100);
    for (int c = 0; c < 40; c++) begin
      out_ready = pat[c%6][0];
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_got("t3", 1, 100, 0);

    // 4: fill four vectors, overflow on the fifth
    got.delete();
    out_ready = 1'b0;
    for (int v = 0; v < 4; v++) push_vec(10 * v);
    chk("t4_stall", {31'b0, array_stall}, 1);
    chk("t4_noovf", {31'b0, overflow}, 0);
    push_vec(40);
    tick();
    chk("t4_ovf", {31'b0, overflow}, 1);
    out_ready = 1'b1;
    repeat (60) tick();
    check_got("t4", 4, 0, 10);
    chk("t4_sticky", {31'b0, overflow}, 1);

    // 5: write into full FIFOs on the cycle of the final pop
    do_reset();
    got.delete();
    out_ready = 1'b0;
    for (int v = 0; v < 4; v++) push_vec(200 + 10 * v);
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_last) found = 1;
      else tick();
    end
    chk("t5_found", {31'b0, found}, 1);
    res_valid = '1;
    for (int r = 0; r < ROWS; r++) res_in[r*OW +: OW] = 240 + r;
    tick();
    res_valid = '0;
    res_in    = '0;
    chk("t5_noovf", {31'b0, overflow}, 0);
    chk("t5_stall", {31'b0, array_stall}, 1);
    repeat (80) tick();
    check_got("t5", 5, 200, 10);
    chk("t5_noovf_end", {31'b0, overflow}, 0);

    // 6: reset mid-drain
    do_reset();
    got.delete();
    out_ready = 1'b0;
    push_vec(300);
    tick();
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t6_sent3", got.size(), 3);
    rstn = 1'b0;
    #1;
    chk("t6_valid", {31'b0, out_valid}, 0);
    chk("t6_data", out_data, 0);
    chk("t6_last", {31'b0, out_last}, 0);
    tick();
    tick();
    rstn = 1'b1;
    repeat (10) begin
      tick();
      chk("t6_idle", {31'b0, out_valid}, 0);
    end
    got.delete();
    push_vec(400);
    repeat (20) tick();
    check_got("t6", 1, 400, 0);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      res_valid = ROWS'($urandom) & ROWS'($urandom);
      for (int r = 0; r < ROWS; r++) res_in[r*OW +: OW] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    res_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
